// File: rtl/sync_e1of4_reg_master_pkg.sv
// Shared encodings and 1of4 helpers for the synchronous e1of4 register master.
package sync_e1of4_reg_master_pkg;

  localparam logic [1:0] OP_READ    = 2'd0;
  localparam logic [1:0] OP_WRITE   = 2'd1;
  localparam logic [1:0] OP_WRRD    = 2'd2;
  localparam logic [1:0] OP_ILLEGAL = 2'd3;

  typedef logic [2:0] state_t;
  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_ISSUE   = 3'd1;
  localparam state_t ST_ACK     = 3'd2;
  localparam state_t ST_NEUTRAL = 3'd3;
  localparam state_t ST_RDV     = 3'd4;
  localparam state_t ST_RDN     = 3'd5;

  function automatic logic [3:0] bin2onehot4(input logic [1:0] b);
    return 4'b0001 << b;
  endfunction

  function automatic logic [1:0] onehot4_to_bin(input logic [3:0] v);
    return {v[3] | v[2], v[3] | v[1]};
  endfunction

  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'd0) && ((v & (v - 4'd1)) == 4'd0);
  endfunction

  function automatic logic op_is_write(input logic [1:0] op);
    return (op == OP_WRITE) || (op == OP_WRRD);
  endfunction

  function automatic logic op_is_read(input logic [1:0] op);
    return (op == OP_READ) || (op == OP_WRRD);
  endfunction

endpackage

// File: rtl/sync_e1of4_reg_master_if.sv
// Command/response stream plus QDI rails between the master and the e1of4 register.
interface sync_e1of4_reg_master_if;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_op;
  logic [1:0] cmd_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [1:0] rsp_data;
  logic [3:0] Tx;
  logic       Txe;
  logic [2:0] Cx;
  logic       Cxe;
  logic [3:0] Rx;
  logic       Rxe;
  logic       busy;
  logic       err;

  modport master (
    input  cmd_valid, cmd_op, cmd_data, rsp_ready, Txe, Cxe, Rx,
    output cmd_ready, rsp_valid, rsp_data, Tx, Cx, Rxe, busy, err
  );

  modport slave (
    output cmd_valid, cmd_op, cmd_data, rsp_ready, Txe, Cxe, Rx,
    input  cmd_ready, rsp_valid, rsp_data, Tx, Cx, Rxe, busy, err
  );
endinterface

// File: rtl/sync_e1of4_reg_master_qdi_sync_bus.sv
// Multi-stage flop synchroniser for a bus of independent asynchronous signals.
module qdi_sync_bus #(
  parameter int unsigned WIDTH  = 1,
  parameter int unsigned STAGES = 2
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);

  logic [WIDTH-1:0] r_sync [STAGES];

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < STAGES; i++) r_sync[i] <= '0;
    end else begin
      r_sync[0] <= i_d;
      for (int i = 1; i < STAGES; i++) r_sync[i] <= r_sync[i-1];
    end
  end

  assign o_q = r_sync[STAGES-1];

endmodule

// File: rtl/sync_e1of4_reg_master.sv
// Drives e1of4 register Cx/Tx tokens from a command stream and returns Rx reads via a FIFO.
module sync_e1of4_reg_master
  import sync_e1of4_reg_master_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned RSP_DEPTH   = 2,
  parameter int unsigned TIMEOUT     = 1024
) (
  input  logic                           CLK,
  input  logic                           RESET,
  inout  wire                            VDD,
  inout  wire                            GND,
  sync_e1of4_reg_master_if.master        bus
);

  localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
  localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);

  wire w_unused_supply;
  assign w_unused_supply = VDD ^ GND;

  logic [5:0] w_sync_in, w_sync_out;
  logic       w_stxe, w_scxe;
  logic [3:0] w_srx;

  assign w_sync_in = {bus.Txe, bus.Cxe, bus.Rx};

  qdi_sync_bus #(
    .WIDTH (6),
    .STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk  (CLK),
    .i_rst_n(RESET),
    .i_d    (w_sync_in),
    .o_q    (w_sync_out)
  );

  assign w_stxe = w_sync_out[5];
  assign w_scxe = w_sync_out[4];
  assign w_srx  = w_sync_out[3:0];

  state_t     r_state, w_state_d;
  logic [1:0] r_op, r_data;
  logic [3:0] r_tx, w_tx_d;
  logic [2:0] r_cx, w_cx_d;
  logic       r_rxe, w_rxe_d;
  logic       r_err, w_err_set;
  logic       r_run, w_load, w_push;
  logic [31:0] r_cnt;

  logic [1:0]       r_mem [RSP_DEPTH];
  logic [PTR_W-1:0] r_wptr, r_rptr;
  logic [CNT_W-1:0] r_count;

  logic w_wr, w_rd, w_en_hi, w_en_lo, w_fifo_full, w_fifo_empty;
  logic w_cmd_ready, w_accept, w_pop, w_rx_multi, w_timeout;

  assign w_wr         = op_is_write(r_op);
  assign w_rd         = op_is_read(r_op);
  assign w_en_hi      = w_scxe && (!w_wr || w_stxe);
  assign w_en_lo      = !w_scxe && (!w_wr || !w_stxe);
  assign w_fifo_full  = (r_count == CNT_W'(RSP_DEPTH));
  assign w_fifo_empty = (r_count == '0);
  // r_run keeps cmd_ready low until the first clock after reset release.
  assign w_cmd_ready  = r_run && (r_state == ST_IDLE) &&
                        (!op_is_read(bus.cmd_op) || !w_fifo_full);
  assign w_accept     = bus.cmd_valid && w_cmd_ready;
  assign w_pop        = bus.rsp_ready && !w_fifo_empty;
  assign w_rx_multi   = (w_srx != 4'd0) && !is_onehot4(w_srx);
  assign w_timeout    = (TIMEOUT != 0) && (r_cnt == TIMEOUT - 1);

  always_comb begin
    w_state_d = r_state;
    w_tx_d    = r_tx;
    w_cx_d    = r_cx;
    w_rxe_d   = r_rxe;
    w_push    = 1'b0;
    w_load    = 1'b0;
    w_err_set = w_rx_multi;
    case (r_state)
      ST_IDLE: begin
        if (w_accept) begin
          if (bus.cmd_op == OP_ILLEGAL) begin
            w_err_set = 1'b1;
          end else begin
            w_load    = 1'b1;
            w_state_d = ST_ISSUE;
          end
        end
      end
      ST_ISSUE: begin
        if (w_en_hi) begin
          w_cx_d    = 3'b001 << r_op;
          w_tx_d    = w_wr ? bin2onehot4(r_data) : 4'd0;
          w_state_d = ST_ACK;
        end
      end
      ST_ACK: begin
        if (w_en_lo) begin
          w_tx_d    = 4'd0;
          w_cx_d    = 3'd0;
          w_state_d = ST_NEUTRAL;
        end
      end
      ST_NEUTRAL: begin
        if (w_en_hi) w_state_d = w_rd ? ST_RDV : ST_IDLE;
      end
      ST_RDV: begin
        if (is_onehot4(w_srx)) begin
          w_push    = 1'b1;
          w_rxe_d   = 1'b0;
          w_state_d = ST_RDN;
        end
      end
      ST_RDN: begin
        if (w_srx == 4'd0) begin
          w_rxe_d   = 1'b1;
          w_state_d = ST_IDLE;
        end
      end
      default: w_state_d = ST_IDLE;
    endcase
    // A wait state that made no progress for TIMEOUT cycles abandons the token.
    if ((r_state != ST_IDLE) && (w_state_d == r_state) && w_timeout) begin
      w_err_set = 1'b1;
      w_tx_d    = 4'd0;
      w_cx_d    = 3'd0;
      w_rxe_d   = 1'b1;
      w_state_d = ST_IDLE;
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state <= ST_IDLE;
      r_op    <= OP_READ;
      r_data  <= 2'd0;
      r_tx    <= 4'd0;
      r_cx    <= 3'd0;
      r_rxe   <= 1'b1;
      r_err   <= 1'b0;
      r_run   <= 1'b0;
      r_cnt   <= 32'd0;
    end else begin
      r_run   <= 1'b1;
      r_state <= w_state_d;
      r_tx    <= w_tx_d;
      r_cx    <= w_cx_d;
      r_rxe   <= w_rxe_d;
      r_cnt   <= (w_state_d != r_state) ? 32'd0 : r_cnt + 32'd1;
      if (w_err_set) r_err <= 1'b1;
      if (w_load) begin
        r_op   <= bus.cmd_op;
        r_data <= bus.cmd_data;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= (r_wptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : r_wptr + PTR_W'(1);
      if (w_pop)  r_rptr <= (r_rptr == PTR_W'(RSP_DEPTH - 1)) ? '0 : r_rptr + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CNT_W'(1);
        2'b01:   r_count <= r_count - CNT_W'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (w_push) r_mem[r_wptr] <= onehot4_to_bin(w_srx);
  end

  assign bus.cmd_ready = w_cmd_ready;
  assign bus.rsp_valid = !w_fifo_empty;
  assign bus.rsp_data  = r_mem[r_rptr];
  assign bus.Tx        = r_tx;
  assign bus.Cx        = r_cx;
  assign bus.Rxe       = r_rxe;
  assign bus.busy      = (r_state != ST_IDLE);
  assign bus.err       = r_err;

endmodule

// File: tb/tb_sync_e1of4_reg_master.sv
// Directed bench: register model on the QDI rails plus token and response scoreboards.
module tb_sync_e1of4_reg_master;
  import sync_e1of4_reg_master_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  wire  vdd, gnd;
  assign vdd = 1'b1;
  assign gnd = 1'b0;

  int n_checks = 0;
  int n_errors = 0;

  logic [6:0] exp_tok [$];   // {Cx, Tx} expected per token
  logic [1:0] exp_rsp [$];

  int         m_st = 0;
  bit         hold_cxe = 1'b0;
  logic [1:0] m_reg = 2'd3;
  bit         m_rd = 1'b0;

  sync_e1of4_reg_master_if bus();

  sync_e1of4_reg_master #(
    .SYNC_STAGES(2),
    .RSP_DEPTH  (2),
    .TIMEOUT    (1024)
  ) dut (
    .CLK  (clk),
    .RESET(rst_n),
    .VDD  (vdd),
    .GND  (gnd),
    .bus  (bus.master)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Register model: four-phase handshake on Cxe/Txe, returns stored value on Rx.
  initial begin
    bus.Cxe = 1'b1;
    bus.Txe = 1'b1;
    bus.Rx  = 4'd0;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        m_st    = 0;
        bus.Cxe = 1'b1;
        bus.Txe = 1'b1;
        bus.Rx  = 4'd0;
      end else begin
        case (m_st)
          0: if (bus.Cx != 3'd0) begin
               if (exp_tok.size() == 0) chk("unexpected_token", 32'({bus.Cx, bus.Tx}), 32'd0);
               else chk("token", 32'({bus.Cx, bus.Tx}), 32'(exp_tok.pop_front()));
               if (bus.Cx[1] || bus.Cx[2]) m_reg = {bus.Tx[3] | bus.Tx[2], bus.Tx[3] | bus.Tx[1]};
               m_rd = bus.Cx[0] || bus.Cx[2];
               m_st = 1;
             end
          1: if (!hold_cxe) begin
               bus.Cxe = 1'b0;
               if (bus.Tx != 4'd0) bus.Txe = 1'b0;
               m_st = 2;
             end
          2: if (bus.Cx == 3'd0 && bus.Tx == 4'd0) begin
               bus.Cxe = 1'b1;
               bus.Txe = 1'b1;
               m_st = m_rd ? 3 : 0;
             end
          3: begin
               bus.Rx = 4'b0001 << m_reg;
               m_st = 4;
             end
          4: if (!bus.Rxe) begin
               bus.Rx = 4'd0;
               m_st = 0;
             end
          default: m_st = 0;
        endcase
      end
    end
  end

  // Response monitor.
  initial begin
    forever begin
      @(negedge clk);
      if (rst_n && bus.rsp_valid && bus.rsp_ready) begin
        if (exp_rsp.size() == 0) chk("unexpected_rsp", 32'(bus.rsp_valid), 32'd0);
        else chk("rsp_data", 32'(bus.rsp_data), 32'(exp_rsp.pop_front()));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d", n_checks);
    $fatal(1, "watchdog");
  end

  task automatic wait_accept();
    int t = 0;
    do begin @(negedge clk); t++; end while (!bus.cmd_ready && t < 5000);
    if (!bus.cmd_ready) chk("cmd_accept_timeout", 32'(bus.cmd_ready), 32'd1);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b0;
  endtask

  task automatic issue(input logic [1:0] op, input logic [1:0] d);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = op;
    bus.cmd_data  = d;
    wait_accept();
  endtask

  task automatic wr(input logic [1:0] d, input logic [6:0] tok);
    exp_tok.push_back(tok);
    issue(2'd1, d);
  endtask

  task automatic rd(input logic [1:0] e);
    exp_tok.push_back(7'b001_0000);
    exp_rsp.push_back(e);
    issue(2'd0, 2'd0);
  endtask

  task automatic wait_quiet();
    int t = 0;
    do begin @(negedge clk); t++; end while ((bus.busy || m_st != 0) && t < 3000);
    if (t >= 3000) chk("quiet_timeout", 32'(t), 32'd0);
  endtask

  task automatic wait_drain();
    int t = 0;
    while (exp_rsp.size() != 0 && t < 3000) begin @(negedge clk); t++; end
    if (t >= 3000) chk("drain_timeout", 32'(exp_rsp.size()), 32'd0);
  endtask

  task automatic do_reset(input int cycles);
    @(negedge clk); #2;
    rst_n = 1'b0;
    repeat (cycles) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  logic [3:0] oh_tab [4];

  initial begin
    int cnt;
    int t;
    oh_tab = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
    bus.cmd_valid = 1'b0;
    bus.cmd_op    = 2'd0;
    bus.cmd_data  = 2'd0;
    bus.rsp_ready = 1'b1;

    // Reset state
    repeat (10) @(negedge clk);
    chk("rst_tx", 32'(bus.Tx), 32'd0);
    chk("rst_cx", 32'(bus.Cx), 32'd0);
    chk("rst_rxe", 32'(bus.Rxe), 32'd1);
    chk("rst_cmd_ready", 32'(bus.cmd_ready), 32'd0);
    chk("rst_err", 32'(bus.err), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("cmd_ready_after_rst", 32'(bus.cmd_ready), 32'd1);

    // Write 10: Cx=010, Tx=0100, asserted one cycle after acceptance
    wr(2'b10, 7'b010_0100);
    @(negedge clk);
    chk("lat_before", 32'(bus.Cx), 32'd0);
    @(negedge clk);
    chk("lat_one_cycle", 32'({bus.Cx, bus.Tx}), 32'(7'b010_0100));
    wait_quiet();
    repeat (5) @(negedge clk);
    chk("write_no_rsp", 32'(bus.rsp_valid), 32'd0);

    // Read returns the model's stored value (10 from the write)
    rd(2'b10);
    wait_quiet();
    wait_drain();
    chk("rxe_restored", 32'(bus.Rxe), 32'd1);

    // Write/read pairs then write+read
    for (int i = 0; i < 4; i++) begin
      wr(2'(i), {3'b010, oh_tab[i]});
      rd(2'(i));
    end
    exp_tok.push_back(7'b100_0010);
    exp_rsp.push_back(2'b01);
    issue(2'd2, 2'b01);
    wait_quiet();
    wait_drain();

    // Backpressure: two responses fill the FIFO, third read stalls
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    wr(2'b00, 7'b010_0001);
    rd(2'b00);
    wr(2'b10, 7'b010_0100);
    rd(2'b10);
    wr(2'b11, 7'b010_1000);
    wait_quiet();
    exp_tok.push_back(7'b001_0000);
    exp_rsp.push_back(2'b11);
    @(posedge clk); #1;
    bus.cmd_valid = 1'b1;
    bus.cmd_op    = 2'd0;
    cnt = 0;
    repeat (50) begin
      @(negedge clk);
      if (bus.cmd_ready) cnt++;
    end
    chk("bp_blocked", 32'(cnt), 32'd0);
    chk("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    wait_accept();
    wait_quiet();
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    wait_drain();
    chk("no_err_normal", 32'(bus.err), 32'd0);

    // Illegal op: sets err, no rail activity
    issue(2'd3, 2'd2);
    cnt = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.Cx != 3'd0 || bus.Tx != 4'd0) cnt++;
    end
    chk("op11_rails", 32'(cnt), 32'd0);
    chk("op11_err", 32'(bus.err), 32'd1);
    chk("op11_busy", 32'(bus.busy), 32'd0);
    do_reset(3);
    chk("err_cleared_by_rst", 32'(bus.err), 32'd0);

    // Multi-hot Rx while idle: err, nothing pushed
    @(posedge clk); #1;
    bus.Rx = 4'b0011;
    repeat (6) @(negedge clk);
    chk("rx_multi_err", 32'(bus.err), 32'd1);
    chk("rx_multi_no_push", 32'(bus.rsp_valid), 32'd0);
    @(posedge clk); #1;
    bus.Rx = 4'd0;
    do_reset(3);

    // Timeout: model never lowers Cxe after the token
    hold_cxe = 1'b1;
    wr(2'b11, 7'b010_1000);
    t = 0;
    do begin @(negedge clk); t++; end while (bus.busy && t < 3000);
    chk("timeout_window", 32'((t > 1020) && (t < 1040)), 32'd1);
    chk("timeout_err", 32'(bus.err), 32'd1);
    chk("timeout_cx", 32'(bus.Cx), 32'd0);
    chk("timeout_tx", 32'(bus.Tx), 32'd0);
    chk("timeout_rxe", 32'(bus.Rxe), 32'd1);
    do_reset(3);

    // Asynchronous reset mid-handshake neutralises rails without a clock edge
    wr(2'b01, 7'b010_0010);
    repeat (2) @(negedge clk);
    chk("pre_async_cx", 32'(bus.Cx), 32'(3'b010));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_rails", 32'({bus.Cx, bus.Tx}), 32'd0);
    hold_cxe = 1'b0;
    repeat (3) @(negedge clk);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    chk("tok_queue_empty", 32'(exp_tok.size()), 32'd0);
    chk("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/sync_e1of4_reg_master.md
Name: sync_e1of4_reg_master

Overview:
Clocked master that drives the e1of4 register's QDI input channels from a synchronous command stream.
- Converts each binary command into a 1of3 control token on Cx and, for writes, a 1of4 data token on Tx, using a four-phase enable handshake.
- Captures the 1of4 read token the register returns on Rx and delivers it as binary on a valid/ready response port.
- Sits directly upstream (and on the return path downstream) of the register. It replaces the behavioural bench drivers in silicon.

Parameters:
SYNC_STAGES, 2, flops in each synchroniser on Txe, Cxe and Rx[3:0]
RSP_DEPTH, 2, response FIFO entries
TIMEOUT, 1024, cycles allowed per handshake wait before error; 0 disables the timeout

Ports:
CLK  input  1  clock
RESET  input  1  asynchronous active-low reset
VDD  inout  1  supply, netlist compatibility only, unused
GND  inout  1  ground, netlist compatibility only, unused
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted this cycle when high with cmd_valid
cmd_op  input  2  00 read, 01 write, 10 write+read, 11 illegal
cmd_data  input  2  write data, binary
rsp_valid  output  1  read data available
rsp_ready  input  1  consumer takes rsp_data
rsp_data  output  2  read data, binary
Tx  output  4  1of4 data rails
Txe  input  1  data enable; high = receiver ready
Cx  output  3  1of3 control rails; Cx[op] is the rail driven
Cxe  input  1  control enable; high = receiver ready
Rx  input  4  1of4 read-data rails
Rxe  output  1  read enable; high = ready for a token
busy  output  1  high in any state other than IDLE
err  output  1  sticky error flag

Behaviour:
- Reset state: Tx=0, Cx=0, Rxe=1, cmd_ready=0, rsp_valid=0, err=0, busy=0, FIFO empty, FSM in IDLE. The reset is asynchronous, so the rails go neutral immediately when RESET falls. Reset asserted mid-handshake abandons the token; no recovery is attempted.
- Txe, Cxe and Rx are used only through the SYNC_STAGES synchronisers (sTxe, sCxe, sRx). Tx, Cx and Rxe are driven directly from flops, so they are glitch-free.
- A write is any op of 01 or 10. A read is any op of 00 or 10.
- Command acceptance: cmd_ready=1 only when the FSM is in IDLE and, for a read op, the FIFO has a free slot. The command is accepted on the cycle where cmd_valid and cmd_ready are both high.
- Op 11: accepted, sets err, sends no token, FSM stays in IDLE.
- FSM states and transitions:
  - IDLE: accept a command -> ISSUE.
  - ISSUE: wait for sCxe=1, plus sTxe=1 if a write. Then, on one clock edge, set Cx[op]=1 and, if a write, Tx[cmd_data]=1 (one-hot) -> ACK.
  - ACK: wait for sCxe=0, plus sTxe=0 if a write. Then set Tx=0 and Cx=0 -> NEUTRAL.
  - NEUTRAL: wait for sCxe=1, plus sTxe=1 if a write. Then -> RDV if a read, else -> IDLE.
  - RDV: wait for sRx to be one-hot. Push its binary index into the FIFO and set Rxe=0 -> RDN.
  - RDN: wait for sRx=0. Set Rxe=1 -> IDLE.
- Latency: rails are asserted 1 cycle after acceptance when the synchronised enables are already high.
- Rx error: sRx with more than one rail high, in any state, sets err. In RDV such a value is never pushed.
- Timeout: each wait state has a cycle counter that resets on every state entry. Reaching TIMEOUT sets err, drives Tx=0, Cx=0, Rxe=1 and returns the FSM to IDLE.
- err is cleared only by reset.
- FIFO: first-in first-out. rsp_valid=1 whenever it is non-empty. A push and a pop in the same cycle are both honoured, and the FIFO is never overrun because of the cmd_ready gating.

Decomposition:
- Shared package holds:
  - op encodings: OP_READ=0, OP_WRITE=1, OP_WRRD=2
  - FSM state enumeration
  - functions: bin2onehot4, onehot4_to_bin, is_onehot4
- Natural sub-module: qdi_sync_bus, a parameterised N-bit multi-stage synchroniser with asynchronous active-low reset. It is instantiated for {Txe, Cxe, Rx}.

Test Plan:
- Reset: hold RESET=0 for 10 cycles -> Tx=0, Cx=0, Rxe=1, cmd_ready=0, err=0. Release -> cmd_ready=1.
- Write: op=01, data=10 -> Cx=010 and Tx=0100 asserted together. Model lowers Cxe and Txe -> rails return to 0. Enables rise -> IDLE, no response produced.
- Read: op=00 -> Cx=001, Tx stays 0. Model returns Rx=1000 -> rsp_data=11, Rxe low until Rx=0, then high.
- Sequence: write 00/01/10/11, each followed by a read -> responses 00, 01, 10, 11 in order. Then op=10 with data=01 -> response 01.
- Backpressure: hold rsp_ready=0 and issue 3 reads -> cmd_ready stays low after 2 responses are queued. Drain one -> third read proceeds.
- Errors: model holds Cxe high after assertion for 1024 cycles -> err=1, rails neutral, FSM in IDLE. Also Rx=0011 -> err=1 with no FIFO push. op=11 -> err=1 with no rail activity.
